demux4_dispatch: RTL

DEMUX4_DISPATCH -- requirements
Module: demux4_dispatch

---
 rtl/demux4_pkg.sv | 7 +
 rtl/demux4_dispatch_if.sv | 25 ++
 rtl/demux4_fifo2.sv | 48 ++++
 rtl/demux4_dispatch.sv | 51 +++++
 4 files changed

// File: rtl/demux4_pkg.sv
// Shared types and constants for the 4-way dispatch demux.
package demux4_pkg;
  localparam int unsigned NUM_DEST   = 4;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef logic [1:0] dest_sel_t;
endpackage

// File: rtl/demux4_dispatch_if.sv
// Upstream handshake plus four downstream ready/valid channels of the dispatch demux.
interface demux4_dispatch_if
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  dest_sel_t                 s;
  logic [NUM_DEST-1:0]       out_valid;
  logic [NUM_DEST-1:0]       out_ready;
  logic [NUM_DEST*WIDTH-1:0] out_data;

  // master: the environment driving the block; slave: the block itself
  modport master (
    output in_valid, in_data, s, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, s, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux4_fifo2.sv
// Two-entry per-channel FIFO; head entry is driven straight from storage.
module demux4_fifo2
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == OCC_W'(FIFO_DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // push into a full FIFO is refused even when it pops in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end
endmodule

// File: rtl/demux4_dispatch.sv
// Routes each accepted payload to one of four 2-deep FIFO channels chosen by s.
// Optional per-channel pop counters under DEMUX4_DISPATCH_PERF_CNT_EN.
module demux4_dispatch
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef DEMUX4_DISPATCH_PERF_CNT_EN
  output logic [NUM_DEST*CNT_W-1:0] perf_cnt,
`endif
  demux4_dispatch_if.slave          bus
);
  logic [NUM_DEST-1:0] full;
  logic [NUM_DEST-1:0] empty;
  logic [NUM_DEST-1:0] push;
  logic [NUM_DEST-1:0] pop;

  // ready depends only on s and registered occupancy, never on downstream ready
  assign bus.in_ready = !full[bus.s];

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_ch
    assign push[i]          = bus.in_valid && bus.in_ready && (bus.s == dest_sel_t'(i));
    assign pop[i]           = bus.out_ready[i] && !empty[i];
    assign bus.out_valid[i] = !empty[i];

    demux4_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (bus.in_data),
      .dout  (bus.out_data[i*WIDTH +: WIDTH]),
      .full  (full[i]),
      .empty (empty[i])
    );

`ifdef DEMUX4_DISPATCH_PERF_CNT_EN
    logic [CNT_W-1:0] pop_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)         pop_cnt <= '0;
      else if (pop[i]) pop_cnt <= pop_cnt + CNT_W'(1);
    end

    assign perf_cnt[i*CNT_W +: CNT_W] = pop_cnt;
`endif
  end
endmodule
